// File: rtl/multiport_block_memory.sv
// Shared block memory serving NUM_PORTS requesters through one array.
// Round-robin arbitration, fixed access latency, READ/WRITE/BUSYWAIT block handshake.
// One access is in flight at a time; the winner's request is latched when it is granted.
module multiport_block_memory #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [NUM_PORTS-1:0]             READ,
  input  logic [NUM_PORTS-1:0]             WRITE,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ADDRESS,
  input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] WRITEDATA,
  output logic [NUM_PORTS*BLOCK_WIDTH-1:0] READDATA,
  output logic [NUM_PORTS-1:0]             BUSYWAIT
);

  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // Benches preload this array by name.
  logic [BLOCK_WIDTH-1:0] MEM_ARRAY [DEPTH];

  state_e                          state_q, state_d;
  logic [PortW-1:0]                grant_q, grant_d;
  logic [PortW-1:0]                last_grant_q, last_grant_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            op_write_q, op_write_d;
  logic [IdxW-1:0]                 addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]          wdata_q, wdata_d;
  logic [NUM_PORTS*BLOCK_WIDTH-1:0] readdata_q;

  logic [NUM_PORTS-1:0]   req;
  logic                   any_req;
  logic [PortW-1:0]       sel;
  logic [PortW-1:0]       cand;
  logic                   sel_write;
  logic [IdxW-1:0]        sel_addr;
  logic [BLOCK_WIDTH-1:0] sel_wdata;
  logic                   commit_wr;
  logic                   commit_rd;

  // Address bits above the array index are ignored so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDRESS;

  assign req = READ | WRITE;

  // Round-robin pick: first requester scanning upward from last_grant+1.
  always_comb begin
    any_req = 1'b0;
    sel     = last_grant_q;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PortW'((32'(last_grant_q) + k) % NUM_PORTS);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  // Mux the selected port's op, index and write block.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (PortW'(p) == sel) begin
        sel_write = WRITE[p];
        sel_addr  = ADDRESS[p*ADDR_WIDTH +: IdxW];
        sel_wdata = WRITEDATA[p*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
    end
  end

  // Next-state logic: grant in idle, count down in access, abort if the requester leaves.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    commit_wr    = 1'b0;
    commit_rd    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StAccess;
          grant_d      = sel;
          last_grant_d = sel;
          cnt_d        = CntW'(LATENCY - 1);
          op_write_d   = sel_write;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
        end
      end
      StAccess: begin
        if (!req[grant_q]) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d   = StDone;
          commit_wr = op_write_q;
          commit_rd = !op_write_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state and registered read blocks; reset leaves the array alone.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= PortW'(NUM_PORTS - 1);
      cnt_q        <= '0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      readdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if (commit_rd) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (PortW'(p) == grant_q) begin
            readdata_q[p*BLOCK_WIDTH +: BLOCK_WIDTH] <= MEM_ARRAY[addr_q];
          end
        end
      end
    end
  end

  // Array write on the edge that ends the access; a reset on that edge drops it.
  always_ff @(posedge CLK) begin
    if (RESET && commit_wr) begin
      MEM_ARRAY[addr_q] <= wdata_q;
    end
  end

  assign READDATA = readdata_q;

  // Stall every requester except the granted one in its done cycle.
  always_comb begin
    BUSYWAIT = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      BUSYWAIT[p] = req[p] & ~((state_q == StDone) && (grant_q == PortW'(p)));
    end
  end

endmodule

// File: tb/tb_multiport_block_memory.sv
// Directed bench for multiport_block_memory: default 2-port instance plus a 3-port,
// latency-1, 32-bit instance. Expected completions go into a scoreboard queue.
module tb_multiport_block_memory;

  localparam int NP  = 2;
  localparam int BW  = 128;
  localparam int AW  = 28;
  localparam int LAT = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                RESET;
  logic [NP-1:0]       rd, wr, busy;
  logic [NP*AW-1:0]    addr_bus;
  logic [NP*BW-1:0]    wdata_bus, rdata;

  logic [2:0]          rd3, wr3, b3;
  logic [3*AW-1:0]     a3;
  logic [3*32-1:0]     wd3, rdd3;

  multiport_block_memory dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (rd),
    .WRITE     (wr),
    .ADDRESS   (addr_bus),
    .WRITEDATA (wdata_bus),
    .READDATA  (rdata),
    .BUSYWAIT  (busy)
  );

  multiport_block_memory #(
    .NUM_PORTS   (3),
    .BLOCK_WIDTH (32),
    .LATENCY     (1)
  ) dut3 (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (rd3),
    .WRITE     (wr3),
    .ADDRESS   (a3),
    .WRITEDATA (wd3),
    .READDATA  (rdd3),
    .BUSYWAIT  (b3)
  );

  typedef struct packed {
    int           port;
    int           cyc;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] PatA5 = {16{8'hA5}};
  localparam logic [127:0] Pat12 = 128'h1234;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input int c, input logic [127:0] d);
    exp_t e;
    e.port = p;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  // Single uncontested access from idle; val is write data or expected read data.
  task automatic access(input int p, input bit we, input int addr, input logic [127:0] val);
    int   n;
    exp_t e;
    n = 0;
    if (!we) push(p, LAT + 1, val);
    rd[p] = !we;
    wr[p] = we;
    addr_bus[p*AW +: AW]  = 28'(addr);
    wdata_bus[p*BW +: BW] = val;
    #1;
    check("busy_first_cycle", 128'(busy[p]), 128'(1));
    while (busy[p] && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("access_latency", 128'(n), 128'(LAT + 1));
    if (!we) begin
      e = sb.pop_front();
      check("read_data", rdata[e.port*BW +: BW], e.data);
    end
    rd[p] = 1'b0;
    wr[p] = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Hold the current requests for ncyc edges, matching each completion to the scoreboard.
  task automatic contend(input int ncyc);
    exp_t e;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge CLK);
      #1;
      for (int p = 0; p < NP; p++) begin
        if ((rd[p] | wr[p]) && !busy[p]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_done: port %0d at cycle %0d, none required", p, k);
          end else begin
            e = sb.pop_front();
            check("done_port", 128'(p), 128'(e.port));
            check("done_cycle", 128'(k), 128'(e.cyc));
            check("done_data", rdata[p*BW +: BW], e.data);
          end
        end
      end
    end
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    rd = '0;
    wr = '0;
    @(posedge CLK);
    #1;
  endtask

  task automatic write3(input int p, input int addr, input logic [31:0] val);
    int n;
    n = 0;
    wr3[p] = 1'b1;
    a3[p*AW +: AW] = 28'(addr);
    wd3[p*32 +: 32] = val;
    #1;
    check("p3_busy_first_cycle", 128'(b3[p]), 128'(1));
    while (b3[p] && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("p3_write_latency", 128'(n), 128'(2));
    wr3[p] = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic contend3(input int ncyc);
    exp_t e;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge CLK);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (rd3[p] && !b3[p]) begin
          if (sb3.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL p3_unexpected_done: port %0d at cycle %0d, none required", p, k);
          end else begin
            e = sb3.pop_front();
            check("p3_done_port", 128'(p), 128'(e.port));
            check("p3_done_cycle", 128'(k), 128'(e.cyc));
            check("p3_done_data", 128'(rdd3[p*32 +: 32]), e.data);
          end
        end
      end
    end
    check("p3_scoreboard_drained", 128'(sb3.size()), 128'(0));
    rd3 = '0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e3;
    RESET = 1'b0;
    rd = '0; wr = '0; addr_bus = '0; wdata_bus = '0;
    rd3 = '0; wr3 = '0; a3 = '0; wd3 = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_rdata0", rdata[0 +: BW], 128'(0));
    check("reset_rdata1", rdata[BW +: BW], 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_p3_rdata", 128'(rdd3), 128'(0));
    check("reset_p3_busy", 128'(b3), 128'(0));
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Preload through the port, then read back.
    access(0, 1'b1, 5, PatA5);
    access(0, 1'b0, 5, PatA5);
    check("port1_untouched", rdata[BW +: BW], 128'(0));

    // Write on port 1, read on port 0, including a wrapped address.
    access(1, 1'b1, 9, Pat12);
    access(0, 1'b0, 9, Pat12);
    access(0, 1'b0, 5, PatA5);
    access(0, 1'b0, 9 + 256, Pat12);
    access(1, 1'b0, 5, PatA5);

    // Contention straight after reset: port 0 first, then strict alternation.
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(k % 2, 5 + 6 * k, (k % 2 == 0) ? PatA5 : Pat12);
    end
    addr_bus[0 +: AW]  = 28'd5;
    addr_bus[AW +: AW] = 28'd9;
    rd = 2'b11;
    contend(36);

    // Abort: port 1 write to 3 dropped after one access cycle.
    access(0, 1'b1, 3, 128'(0));
    wr[1] = 1'b1;
    addr_bus[AW +: AW] = 28'd3;
    wdata_bus[BW +: BW] = '1;
    @(posedge CLK);
    #1;
    check("abort_busy_in_access", 128'(busy[1]), 128'(1));
    @(posedge CLK);
    #1;
    wr[1] = 1'b0;
    @(posedge CLK);
    #1;
    access(0, 1'b0, 3, 128'(0));
    check("abort_rdata1_kept", rdata[BW +: BW], Pat12);

    // Reset in the middle of a port 0 write; port 0 must still win next.
    access(0, 1'b0, 9, Pat12);
    access(0, 1'b1, 7, 128'(0));
    wr[0] = 1'b1;
    addr_bus[0 +: AW] = 28'd7;
    wdata_bus[0 +: BW] = 128'h7777;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    wr[0] = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    check("midreset_rdata0", rdata[0 +: BW], 128'(0));
    check("midreset_rdata1", rdata[BW +: BW], 128'(0));
    push(0, 5, 128'(0));
    push(1, 11, PatA5);
    addr_bus[0 +: AW]  = 28'd7;
    addr_bus[AW +: AW] = 28'd5;
    rd = 2'b11;
    contend(12);

    // Three ports, latency 1: writes, then full-load round robin every 3 cycles.
    for (int p = 0; p < 3; p++) begin
      write3(p, p + 1, 32'hC0DE_0000 + 32'(p));
    end
    for (int k = 0; k < 6; k++) begin
      e3.port = k % 3;
      e3.cyc  = 2 + 3 * k;
      e3.data = 128'(32'hC0DE_0000 + 32'(k % 3));
      sb3.push_back(e3);
    end
    for (int p = 0; p < 3; p++) begin
      a3[p*AW +: AW] = 28'(p + 1);
    end
    rd3 = 3'b111;
    contend3(18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish");
    $fatal(1, "watchdog expired");
  end

endmodule
